// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: multi-cycle control sequencer in front of the ALU.
// It accepts one instruction, reads its registers, drives the ALU for one
// cycle, then either hands the result to the register file or reports an
// exception.
module alu_issue_sequencer #(
  parameter bit TRAP_ON_OVERFLOW = 1'b1,
  parameter bit REG0_HARDWIRED   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic        alu_add_sub,
  output logic [1:0]  alu_logic_fn,
  output logic [1:0]  alu_fn_class,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  input  logic        exc_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_TRAP   = 3'd4
  } state_t;

  localparam logic [1:0] CLASS_ARITH = 2'b00;
  localparam logic [1:0] CLASS_LOGIC = 2'b01;
  localparam logic [1:0] CLASS_LUI   = 2'b10;
  localparam logic [1:0] CLASS_SLT   = 2'b11;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  cause_q, cause_d;

  // Instruction fields, always taken from the latched copy.
  logic [5:0]  opcode;
  logic [4:0]  rd_field;
  logic [4:0]  rs_field;
  logic [4:0]  rt_field;
  logic [15:0] imm_field;
  logic [3:0]  funct_field;

  assign opcode      = instr_q[31:26];
  assign rd_field    = instr_q[25:21];
  assign rs_field    = instr_q[20:16];
  assign rt_field    = instr_q[15:11];
  assign imm_field   = instr_q[15:0];
  assign funct_field = instr_q[3:0];

  // Decoded control, valid whenever instr_q holds an accepted instruction.
  logic        dec_legal;
  logic        dec_add_sub;
  logic [1:0]  dec_logic_fn;
  logic [1:0]  dec_fn_class;
  logic        dec_use_imm;
  logic        dec_imm_sext;
  logic        dec_ovf_en;
  logic [31:0] imm_ext;

  // Instruction decode: R-type selects by funct, I-type by opcode.
  always_comb begin
    dec_legal    = 1'b1;
    dec_add_sub  = 1'b0;
    dec_logic_fn = 2'b00;
    dec_fn_class = CLASS_ARITH;
    dec_use_imm  = 1'b0;
    dec_imm_sext = 1'b0;
    dec_ovf_en   = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct_field)
          4'd0: dec_ovf_en = 1'b1;
          4'd1: begin dec_add_sub = 1'b1; dec_ovf_en = 1'b1; end
          4'd2: begin dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b00; end
          4'd3: begin dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b01; end
          4'd4: begin dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b10; end
          4'd5: begin dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b11; end
          4'd6: begin dec_fn_class = CLASS_SLT; dec_add_sub = 1'b1; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'b000001: begin
        dec_use_imm = 1'b1; dec_imm_sext = 1'b1; dec_ovf_en = 1'b1;
      end
      6'b000010: begin
        dec_use_imm = 1'b1; dec_imm_sext = 1'b1; dec_ovf_en = 1'b1;
        dec_add_sub = 1'b1;
      end
      6'b000011: begin
        dec_use_imm = 1'b1; dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b00;
      end
      6'b000100: begin
        dec_use_imm = 1'b1; dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b01;
      end
      6'b000101: begin
        dec_use_imm = 1'b1; dec_fn_class = CLASS_LOGIC; dec_logic_fn = 2'b10;
      end
      6'b000110: begin
        // The ALU itself shifts the zero-extended immediate into the top half.
        dec_use_imm = 1'b1; dec_fn_class = CLASS_LUI;
      end
      6'b000111: begin
        dec_use_imm = 1'b1; dec_imm_sext = 1'b1; dec_fn_class = CLASS_SLT;
        dec_add_sub = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign imm_ext = dec_imm_sext ? {{16{imm_field[15]}}, imm_field}
                                : {16'h0000, imm_field};

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      result_q <= '0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      result_q <= result_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state and register-load logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    result_d = result_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rs_d = rs_data;
        rt_d = rt_data;
        if (!dec_legal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        // Overflow only means something for the signed add/subtract forms.
        if (TRAP_ON_OVERFLOW && dec_ovf_en && alu_overflow) begin
          cause_d = CAUSE_OVERFLOW;
          state_d = S_TRAP;
        end else if (REG0_HARDWIRED && (rd_field == 5'd0)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      S_TRAP: begin
        if (exc_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state; everything is zero outside its own state.
  always_comb begin
    instr_ready  = 1'b0;
    rs_addr      = 5'd0;
    rt_addr      = 5'd0;
    alu_x        = '0;
    alu_y        = '0;
    alu_add_sub  = 1'b0;
    alu_logic_fn = 2'b00;
    alu_fn_class = 2'b00;
    wb_valid     = 1'b0;
    wb_addr      = 5'd0;
    wb_data      = '0;
    exc_valid    = 1'b0;
    exc_cause    = 2'b00;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: instr_ready = 1'b1;
      S_DECODE: begin
        rs_addr = rs_field;
        rt_addr = rt_field;
      end
      S_EXEC: begin
        alu_x        = rs_q;
        alu_y        = dec_use_imm ? imm_ext : rt_q;
        alu_add_sub  = dec_add_sub;
        alu_logic_fn = dec_logic_fn;
        alu_fn_class = dec_fn_class;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_addr  = rd_field;
        wb_data  = result_q;
      end
      S_TRAP: begin
        exc_valid = 1'b1;
        exc_cause = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: a register file and ALU model
// around two instances (overflow trapping on and off), hand-computed vectors.
module tb_alu_issue_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        wb_ready;
  logic        exc_ack;

  // Instance with default parameters.
  logic        instr_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_x, alu_y;
  logic        alu_add_sub;
  logic [1:0]  alu_logic_fn, alu_fn_class;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic        busy;

  // Instance with overflow trapping disabled.
  logic        n_instr_ready;
  logic [4:0]  n_rs_addr, n_rt_addr;
  logic [31:0] n_rs_data, n_rt_data;
  logic [31:0] n_alu_x, n_alu_y;
  logic        n_alu_add_sub;
  logic [1:0]  n_alu_logic_fn, n_alu_fn_class;
  logic [31:0] n_alu_result;
  logic        n_alu_overflow;
  logic        n_wb_valid;
  logic [4:0]  n_wb_addr;
  logic [31:0] n_wb_data;
  logic        n_exc_valid;
  logic [1:0]  n_exc_cause;
  logic        n_busy;

  logic [31:0] regs [32];

  int n_vec;
  int n_miss;

  // Reference ALU: returns {overflow, result}.
  function automatic logic [32:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic as, input logic [1:0] lf,
                                            input logic [1:0] fc);
    logic [31:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (fc)
      2'b00: begin
        r = as ? (x - y) : (x + y);
        o = as ? ((x[31] != y[31]) && (r[31] != x[31]))
               : ((x[31] == y[31]) && (r[31] != x[31]));
      end
      2'b01: begin
        case (lf)
          2'b00: r = x & y;
          2'b01: r = x | y;
          2'b10: r = x ^ y;
          default: r = ~(x | y);
        endcase
      end
      2'b10: r = {y[15:0], 16'h0000};
      default: r = {31'd0, $signed(x) < $signed(y)};
    endcase
    return {o, r};
  endfunction

  assign rs_data   = regs[rs_addr];
  assign rt_data   = regs[rt_addr];
  assign n_rs_data = regs[n_rs_addr];
  assign n_rt_data = regs[n_rt_addr];
  assign {alu_overflow, alu_result} =
    alu_model(alu_x, alu_y, alu_add_sub, alu_logic_fn, alu_fn_class);
  assign {n_alu_overflow, n_alu_result} =
    alu_model(n_alu_x, n_alu_y, n_alu_add_sub, n_alu_logic_fn, n_alu_fn_class);

  alu_issue_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_add_sub(alu_add_sub),
    .alu_logic_fn(alu_logic_fn), .alu_fn_class(alu_fn_class),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_ack(exc_ack),
    .busy(busy)
  );

  alu_issue_sequencer #(.TRAP_ON_OVERFLOW(1'b0), .REG0_HARDWIRED(1'b1)) dut_nt (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(n_instr_ready),
    .rs_addr(n_rs_addr), .rt_addr(n_rt_addr), .rs_data(n_rs_data), .rt_data(n_rt_data),
    .alu_x(n_alu_x), .alu_y(n_alu_y), .alu_add_sub(n_alu_add_sub),
    .alu_logic_fn(n_alu_logic_fn), .alu_fn_class(n_alu_fn_class),
    .alu_result(n_alu_result), .alu_overflow(n_alu_overflow),
    .wb_valid(n_wb_valid), .wb_ready(wb_ready), .wb_addr(n_wb_addr), .wb_data(n_wb_data),
    .exc_valid(n_exc_valid), .exc_cause(n_exc_cause), .exc_ack(exc_ack),
    .busy(n_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net: the directed sequence is short, so this should never fire.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [31:0] i);
    instr       = i;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 32'h0;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [3:0] fn);
    return {6'b000000, rd, rs, rt, 7'b0000000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    wb_ready    = 1'b0;
    exc_ack     = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'h7FFF_FFFE;
    regs[2] = 32'h0000_0001;
    regs[4] = 32'h8000_0000;

    // Reset state
    rst = 1'b1;
    #1;
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    check("rst_alu_x", alu_x, 32'h0);
    step();
    rst = 1'b0;

    // ADD r3 = r1 + r2
    issue(rtype(5'd3, 5'd1, 5'd2, 4'd0));
    check("add_c1_busy", {31'd0, busy}, 32'd1);
    check("add_c1_instr_ready", {31'd0, instr_ready}, 32'd0);
    check("add_c1_rs_addr", {27'd0, rs_addr}, 32'd1);
    check("add_c1_rt_addr", {27'd0, rt_addr}, 32'd2);
    step();
    check("add_c2_fn_class", {30'd0, alu_fn_class}, 32'd0);
    check("add_c2_add_sub", {31'd0, alu_add_sub}, 32'd0);
    check("add_c2_alu_x", alu_x, 32'h7FFF_FFFE);
    check("add_c2_alu_y", alu_y, 32'h0000_0001);
    step();
    check("add_c3_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_c3_wb_addr", {27'd0, wb_addr}, 32'd3);
    check("add_c3_wb_data", wb_data, 32'h7FFF_FFFF);
    check("add_c3_alu_y_idle", alu_y, 32'h0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("add_c4_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("add_c4_wb_valid", {31'd0, wb_valid}, 32'd0);

    // SUBI r5 = r4 - 1 overflows
    issue(itype(6'b000010, 5'd5, 5'd4, 16'h0001));
    step();
    check("subi_c2_add_sub", {31'd0, alu_add_sub}, 32'd1);
    check("subi_c2_alu_y", alu_y, 32'h0000_0001);
    step();
    check("subi_trap_exc_valid", {31'd0, exc_valid}, 32'd1);
    check("subi_trap_exc_cause", {30'd0, exc_cause}, 32'd2);
    check("subi_trap_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("subi_notrap_wb_valid", {31'd0, n_wb_valid}, 32'd1);
    check("subi_notrap_wb_data", n_wb_data, 32'h7FFF_FFFF);
    check("subi_notrap_exc_valid", {31'd0, n_exc_valid}, 32'd0);
    wb_ready = 1'b1;
    exc_ack  = 1'b1;
    step();
    wb_ready = 1'b0;
    exc_ack  = 1'b0;
    check("subi_trap_done", {31'd0, instr_ready}, 32'd1);
    check("subi_notrap_done", {31'd0, n_instr_ready}, 32'd1);

    // ANDI r6 = r1 & 0xF00F
    issue(itype(6'b000011, 5'd6, 5'd1, 16'hF00F));
    step();
    check("andi_alu_y", alu_y, 32'h0000_F00F);
    check("andi_logic_fn", {30'd0, alu_logic_fn}, 32'd0);
    check("andi_fn_class", {30'd0, alu_fn_class}, 32'd1);
    step();
    check("andi_wb_data", wb_data, 32'h0000_F00E);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // SLTI r7 = (r2 < -1)
    issue(itype(6'b000111, 5'd7, 5'd2, 16'hFFFF));
    step();
    check("slti_alu_y", alu_y, 32'hFFFF_FFFF);
    check("slti_add_sub", {31'd0, alu_add_sub}, 32'd1);
    check("slti_fn_class", {30'd0, alu_fn_class}, 32'd3);
    step();
    check("slti_wb_data", wb_data, 32'h0000_0000);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // LUI r9 = 0x1234 << 16
    issue(itype(6'b000110, 5'd9, 5'd0, 16'h1234));
    step();
    check("lui_alu_y", alu_y, 32'h0000_1234);
    check("lui_fn_class", {30'd0, alu_fn_class}, 32'd2);
    step();
    check("lui_wb_data", wb_data, 32'h1234_0000);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Illegal opcode: trap held until acknowledged, wb_ready ignored
    issue(itype(6'b111111, 5'd3, 5'd1, 16'h0000));
    step();
    check("ill_exc_valid", {31'd0, exc_valid}, 32'd1);
    check("ill_exc_cause", {30'd0, exc_cause}, 32'd1);
    check("ill_instr_ready", {31'd0, instr_ready}, 32'd0);
    wb_ready = 1'b1;
    step();
    step();
    wb_ready = 1'b0;
    check("ill_hold_exc_valid", {31'd0, exc_valid}, 32'd1);
    check("ill_hold_instr_ready", {31'd0, instr_ready}, 32'd0);
    check("ill_hold_wb_valid", {31'd0, wb_valid}, 32'd0);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("ill_done_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("ill_done_exc_valid", {31'd0, exc_valid}, 32'd0);

    // Illegal R-type funct
    issue(rtype(5'd3, 5'd1, 5'd2, 4'd7));
    step();
    check("ill_funct_exc_cause", {30'd0, exc_cause}, 32'd1);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;

    // ADD to r0: dropped, back in IDLE right after EXEC
    issue(rtype(5'd0, 5'd1, 5'd2, 4'd0));
    step();
    step();
    check("rd0_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rd0_instr_ready", {31'd0, instr_ready}, 32'd1);

    // SUB r8 = r1 - r2 with wb_ready held low for 5 cycles, exc_ack ignored
    issue(rtype(5'd8, 5'd1, 5'd2, 4'd1));
    step();
    step();
    exc_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("stall_wb_data", wb_data, 32'h7FFF_FFFD);
      step();
    end
    exc_ack  = 1'b0;
    check("stall_wb_addr", {27'd0, wb_addr}, 32'd8);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("stall_done_instr_ready", {31'd0, instr_ready}, 32'd1);

    // Reset pulsed during EXEC abandons the instruction
    issue(rtype(5'd3, 5'd1, 5'd2, 4'd0));
    step();
    check("rstx_in_exec", alu_x, 32'h7FFF_FFFE);
    rst = 1'b1;
    #1;
    check("rstx_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rstx_alu_x", alu_x, 32'h0);
    check("rstx_busy", {31'd0, busy}, 32'd0);
    #1;
    rst = 1'b0;
    step();
    step();
    check("rstx_no_wb", {31'd0, wb_valid}, 32'd0);
    check("rstx_no_exc", {31'd0, exc_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
